// File: rtl/xyolo_macc_v2_if.sv
// Control, configuration, operand and result signals of the xyolo MAC functional unit.
interface xyolo_macc_v2_if #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 10,
  parameter int SHIFT_W = 5
);
  logic                      run;
  logic                      en;
  logic [CNT_W-1:0]          iterations;
  logic [CNT_W-1:0]          period;
  logic [CNT_W-1:0]          delay;
  logic [SHIFT_W-1:0]        shift;
  logic                      bias;
  logic                      leaky;
  logic                      mode;
  logic signed [DATA_W-1:0]  op_a;
  logic signed [DATA_W-1:0]  op_b;
  logic signed [DATA_W-1:0]  op_c;
  logic signed [DATA_W-1:0]  out_data;
  logic                      out_valid;
  logic                      busy;
  logic                      done;

  modport master (
    output run, en, iterations, period, delay, shift, bias, leaky, mode,
           op_a, op_b, op_c,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  run, en, iterations, period, delay, shift, bias, leaky, mode,
           op_a, op_b, op_c,
    output out_data, out_valid, busy, done
  );
endinterface

// File: rtl/xyolo_macc_v2.sv
// xyolo_macc_v2: 4-stage pipelined multiply-accumulate / maxpool unit with an
// iteration/period sequencer, round-half-up shift, saturation and leaky ReLU.
module xyolo_macc_v2 #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int CNT_W   = 10,
  parameter int SHIFT_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  xyolo_macc_v2_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  // Round half up, then arithmetic shift; one guard bit keeps the bias add exact.
  function automatic logic signed [ACC_W:0] f_round_shift(input logic signed [ACC_W-1:0] acc,
                                                         input logic [SHIFT_W-1:0] sh);
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] half;
    v    = {acc[ACC_W-1], acc};
    half = '0;
    if (sh != '0) half = (ACC_W+1)'(1) << (sh - 1'b1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] f_leaky(input logic signed [DATA_W-1:0] s,
                                                      input logic lk);
    return (lk && (s < 0)) ? (s >>> 3) : s;
  endfunction

  state_t                    r_state, w_next;
  logic [CNT_W-1:0]          r_iter, r_period, r_delay;
  logic [CNT_W-1:0]          r_k, r_i, r_dcnt;
  logic [SHIFT_W-1:0]        r_shift;
  logic                      r_bias, r_leaky, r_mode;

  logic                      r_vld_p1, r_first_p1, r_last_p1;
  logic signed [DATA_W-1:0]  r_a_p1, r_b_p1, r_c_p1;
  logic                      r_vld_p2, r_first_p2, r_last_p2;
  logic signed [ACC_W-1:0]   r_prod_p2, r_init_p2, r_a_p2;
  logic                      r_vld_p3, r_last_p3;
  logic signed [ACC_W-1:0]   r_acc_p3;
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_out_data;

  logic                      w_k_last, w_i_last, w_take, w_pipe_empty;
  logic signed [2*DATA_W-1:0] w_mul;
  logic signed [ACC_W-1:0]   w_prod, w_c_ext, w_init, w_acc_next;
  logic signed [DATA_W-1:0]  w_post;

  assign w_k_last     = (r_k == r_period - CNT_W'(1));
  assign w_i_last     = (r_i == r_iter - CNT_W'(1));
  assign w_take       = (r_state == S_RUN) && bus.en;
  assign w_pipe_empty = !r_vld_p1 && !r_vld_p2 && !r_vld_p3;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Sequencer next state; a zero-length run goes straight to the drain check
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.run)
                 w_next = ((bus.iterations == '0) || (bus.period == '0)) ? S_DRAIN : S_DELAY;
      S_DELAY: if (bus.en && (r_dcnt == r_delay)) w_next = S_RUN;
      S_RUN:   if (bus.en && w_k_last && w_i_last) w_next = S_DRAIN;
      S_DRAIN: if (bus.en && w_pipe_empty) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Configuration latch and delay/sample/window counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter <= '0; r_period <= '0; r_delay <= '0; r_shift <= '0;
      r_bias <= 1'b0; r_leaky <= 1'b0; r_mode <= 1'b0;
      r_k <= '0; r_i <= '0; r_dcnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.run) begin
        r_iter  <= bus.iterations; r_period <= bus.period; r_delay <= bus.delay;
        r_shift <= bus.shift; r_bias <= bus.bias; r_leaky <= bus.leaky; r_mode <= bus.mode;
        r_k <= '0; r_i <= '0; r_dcnt <= '0;
      end
      if ((r_state == S_DELAY) && bus.en) r_dcnt <= r_dcnt + CNT_W'(1);
      if (w_take) begin
        if (w_k_last) begin
          r_k <= '0;
          r_i <= r_i + CNT_W'(1);
        end else begin
          r_k <= r_k + CNT_W'(1);
        end
      end
    end
  end

  // ---- stage 1: operand capture with window first/last flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0; r_first_p1 <= 1'b0; r_last_p1 <= 1'b0;
      r_a_p1 <= '0; r_b_p1 <= '0; r_c_p1 <= '0;
    end else if (bus.en) begin
      r_vld_p1   <= w_take;
      r_first_p1 <= (r_k == '0);
      r_last_p1  <= w_k_last;
      r_a_p1     <= bus.op_a;
      r_b_p1     <= bus.op_b;
      r_c_p1     <= bus.op_c;
    end
  end

  assign w_mul   = (2*DATA_W)'(r_a_p1) * (2*DATA_W)'(r_b_p1);
  assign w_prod  = ACC_W'(w_mul);
  assign w_c_ext = ACC_W'(r_c_p1);
  assign w_init  = r_bias ? (w_c_ext <<< r_shift) : '0;

  // ---- stage 2: product and accumulator seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0; r_first_p2 <= 1'b0; r_last_p2 <= 1'b0;
      r_prod_p2 <= '0; r_init_p2 <= '0; r_a_p2 <= '0;
    end else if (bus.en) begin
      r_vld_p2   <= r_vld_p1;
      r_first_p2 <= r_first_p1;
      r_last_p2  <= r_last_p1;
      r_prod_p2  <= w_prod;
      r_init_p2  <= w_init;
      r_a_p2     <= ACC_W'(r_a_p1);
    end
  end

  // The first flag restarts the window, so consecutive windows need no bubble.
  always_comb begin
    w_acc_next = r_acc_p3;
    if (r_mode)
      w_acc_next = (r_first_p2 || (r_a_p2 > r_acc_p3)) ? r_a_p2 : r_acc_p3;
    else
      w_acc_next = (r_first_p2 ? r_init_p2 : r_acc_p3) + r_prod_p2;
  end

  // ---- stage 3: accumulate or running maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p3 <= 1'b0; r_last_p3 <= 1'b0; r_acc_p3 <= '0;
    end else if (bus.en) begin
      r_vld_p3  <= r_vld_p2;
      r_last_p3 <= r_last_p2;
      if (r_vld_p2) r_acc_p3 <= w_acc_next;
    end
  end

  assign w_post = r_mode ? r_acc_p3[DATA_W-1:0]
                         : f_leaky(f_sat(f_round_shift(r_acc_p3, r_shift)), r_leaky);

  // ---- stage 4: post-processed result at window end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0; r_out_data <= '0;
    end else if (bus.en) begin
      r_out_valid <= r_vld_p3 && r_last_p3;
      if (r_vld_p3 && r_last_p3) r_out_data <= w_post;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_xyolo_macc_v2.sv
// Randomized and directed bench for xyolo_macc_v2 against a window-level arithmetic model.
module tb_xyolo_macc_v2;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 40;
  localparam int CNT_W   = 10;
  localparam int SHIFT_W = 5;
  localparam longint OMAX = (longint'(1) <<< (DATA_W-1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (DATA_W-1));

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     cyc = 0;
  bit     en_hist [0:32767];
  int     n_chk = 0;
  int     n_err = 0;
  longint obs_d[$];
  int     obs_c[$];
  int     done_c[$];
  int     qa[$], qb[$], qc[$];

  xyolo_macc_v2_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) ifc ();

  xyolo_macc_v2 #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // cycle counter and per-cycle enable history
  always @(posedge clk) begin
    en_hist[cyc & 32767] <= ifc.en;
    cyc <= cyc + 1;
  end

  // record each newly issued result and every done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.out_valid && (cyc > 0) && en_hist[(cyc-1) & 32767]) begin
        obs_d.push_back(longint'(ifc.out_data));
        obs_c.push_back(cyc);
      end
      if (ifc.done) done_c.push_back(cyc);
    end
  end

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string tag, input int iters, input int per, input int dly,
                          input int sh, input bit bs, input bit lk, input bit md,
                          input int stall_at, input int stall_len);
    longint exp_q[$];
    int     exp_c[$];
    int     last_t[$];
    int     run_cyc, budget, exp_done;
    obs_d.delete(); obs_c.delete(); done_c.delete();
    ifc.iterations = CNT_W'(iters); ifc.period = CNT_W'(per); ifc.delay = CNT_W'(dly);
    ifc.shift = SHIFT_W'(sh); ifc.bias = bs; ifc.leaky = lk; ifc.mode = md;
    ifc.en = 1'b1; ifc.run = 1'b1;
    run_cyc = cyc;
    step();
    ifc.run = 1'b0;
    // configuration changes after acceptance must not matter
    ifc.iterations = CNT_W'($urandom); ifc.period = CNT_W'($urandom); ifc.delay = CNT_W'($urandom);
    ifc.shift = SHIFT_W'($urandom); ifc.bias = 1'($urandom); ifc.leaky = 1'($urandom);
    ifc.mode = 1'($urandom);
    chk_eq({tag, ".busy_on"}, longint'(ifc.busy), 1);
    if (iters > 0 && per > 0) begin
      repeat (dly + 1) step();
      for (int j = 0; j < iters * per; j++) begin
        if (j == stall_at) begin
          ifc.en = 1'b0;
          repeat (stall_len) begin
            ifc.op_a = DATA_W'($urandom); ifc.op_b = DATA_W'($urandom);
            step();
          end
          ifc.en = 1'b1;
        end
        ifc.run  = ($urandom_range(0, 3) == 0);
        ifc.op_a = DATA_W'(qa[j]); ifc.op_b = DATA_W'(qb[j]); ifc.op_c = DATA_W'(qc[j]);
        if ((j % per) == per - 1) last_t.push_back(cyc);
        step();
      end
    end
    ifc.run = 1'b0;
    ifc.op_a = DATA_W'($urandom); ifc.op_b = DATA_W'($urandom); ifc.op_c = DATA_W'($urandom);
    budget = 0;
    while (done_c.size() == 0 && budget < 60) begin
      step();
      budget++;
    end
    chk_eq({tag, ".busy_off"}, longint'(ifc.busy), 0);

    // reference: one result per window from plain arithmetic on the window samples
    for (int w = 0; w < last_t.size(); w++) begin
      longint acc, r;
      int c, n;
      if (md) begin
        acc = qa[w*per];
        for (int k = 1; k < per; k++) if (qa[w*per+k] > acc) acc = qa[w*per+k];
        exp_q.push_back(acc);
      end else begin
        acc = bs ? (longint'(qc[w*per]) <<< sh) : 0;
        for (int k = 0; k < per; k++) acc += longint'(qa[w*per+k]) * longint'(qb[w*per+k]);
        r = (sh > 0) ? ((acc + (longint'(1) <<< (sh-1))) >>> sh) : acc;
        if (r > OMAX) r = OMAX;
        if (r < OMIN) r = OMIN;
        if (lk && r < 0) r = r >>> 3;
        exp_q.push_back(r);
      end
      // a result appears after its last sample has seen four enabled clock edges
      c = last_t[w]; n = 0;
      while (n < 4 && c < cyc) begin
        if (en_hist[c & 32767]) n++;
        c++;
      end
      exp_c.push_back(c);
    end
    exp_done = (exp_c.size() > 0) ? exp_c[exp_c.size()-1] + 1 : run_cyc + 2;

    chk_eq({tag, ".n_out"}, obs_d.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_d.size(); k++) begin
      chk_eq($sformatf("%s.data%0d", tag, k), obs_d[k], exp_q[k]);
      chk_eq($sformatf("%s.cyc%0d", tag, k), obs_c[k], exp_c[k]);
    end
    chk_eq({tag, ".n_done"}, done_c.size(), 1);
    if (done_c.size() > 0) chk_eq({tag, ".done_cyc"}, done_c[0], exp_done);
  endtask

  task automatic rand_ops(input int n, input int lim);
    qa.delete(); qb.delete(); qc.delete();
    for (int j = 0; j < n; j++) begin
      qa.push_back(int'($urandom_range(0, 2*lim - 1)) - lim);
      qb.push_back(int'($urandom_range(0, 2*lim - 1)) - lim);
      qc.push_back(int'($urandom_range(0, 2*lim - 1)) - lim);
    end
  endtask

  task automatic reset_mid_run();
    qa.delete(); qb.delete(); qc.delete();
    for (int j = 0; j < 8; j++) begin
      qa.push_back(j + 1); qb.push_back(2); qc.push_back(0);
    end
    obs_d.delete(); obs_c.delete(); done_c.delete();
    ifc.iterations = CNT_W'(2); ifc.period = CNT_W'(4); ifc.delay = '0;
    ifc.shift = '0; ifc.bias = 1'b0; ifc.leaky = 1'b0; ifc.mode = 1'b0;
    ifc.en = 1'b1; ifc.run = 1'b1;
    step();
    ifc.run = 1'b0;
    step();
    for (int j = 0; j < 7; j++) begin
      ifc.op_a = DATA_W'(qa[j]); ifc.op_b = DATA_W'(qb[j]); ifc.op_c = '0;
      step();
    end
    // first window result (2*(1+2+3+4)) is on the output now
    chk_eq("rst.pre_vld", longint'(ifc.out_valid), 1);
    chk_eq("rst.pre_data", longint'(ifc.out_data), 20);
    rst_n = 1'b0;
    #1;
    chk_eq("rst.busy", longint'(ifc.busy), 0);
    chk_eq("rst.vld", longint'(ifc.out_valid), 0);
    chk_eq("rst.done", longint'(ifc.done), 0);
    chk_eq("rst.data", longint'(ifc.out_data), 0);
    step();
    rst_n = 1'b1;
    obs_d.delete(); done_c.delete();
    repeat (15) step();
    chk_eq("rst.no_out", obs_d.size(), 0);
    chk_eq("rst.no_done", done_c.size(), 0);
    chk_eq("rst.idle", longint'(ifc.busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.run = 1'b0; ifc.en = 1'b1; ifc.iterations = '0; ifc.period = '0; ifc.delay = '0;
    ifc.shift = '0; ifc.bias = 1'b0; ifc.leaky = 1'b0; ifc.mode = 1'b0;
    ifc.op_a = '0; ifc.op_b = '0; ifc.op_c = '0;
    repeat (3) step();
    chk_eq("reset.busy", longint'(ifc.busy), 0);
    chk_eq("reset.vld", longint'(ifc.out_valid), 0);
    chk_eq("reset.done", longint'(ifc.done), 0);
    chk_eq("reset.data", longint'(ifc.out_data), 0);
    rst_n = 1'b1;
    step();

    qa = '{2, 3, 4}; qb = '{5, 6, 7}; qc = '{0, 0, 0};
    run_case("mac56", 1, 3, 0, 0, 0, 0, 0, -1, 0);
    run_case("mac56_stall", 1, 3, 2, 0, 0, 0, 0, 1, 5);

    qa = '{32767, -32768}; qb = '{32767, 32767}; qc = '{0, 0};
    run_case("sat", 2, 1, 0, 0, 0, 0, 0, -1, 0);

    qa = '{6, 5, -6}; qb = '{1, 1, 1}; qc = '{0, 0, 0};
    run_case("round", 3, 1, 1, 2, 0, 0, 0, -1, 0);

    qa = '{-80}; qb = '{1}; qc = '{0};
    run_case("leaky", 1, 1, 0, 0, 0, 1, 0, -1, 0);

    qa = '{2}; qb = '{5}; qc = '{3};
    run_case("bias", 1, 1, 0, 4, 1, 0, 0, -1, 0);

    qa = '{-3, 7, 2, -9, -4, -5}; qb = '{0, 0, 0, 0, 0, 0}; qc = '{0, 0, 0, 0, 0, 0};
    run_case("maxpool", 2, 3, 0, 0, 0, 0, 1, -1, 0);

    qa.delete(); qb.delete(); qc.delete();
    run_case("iter0", 0, 3, 2, 0, 0, 0, 0, -1, 0);
    run_case("per0", 2, 0, 1, 0, 0, 0, 0, -1, 0);

    for (int t = 0; t < 30; t++) begin
      int it, pr, dl, sh, sa;
      it = $urandom_range(1, 4);
      pr = $urandom_range(1, 6);
      dl = $urandom_range(0, 3);
      sh = $urandom_range(0, 15);
      sa = $urandom_range(0, it * pr + 2);
      rand_ops(it * pr, ($urandom_range(0, 1) == 1) ? 32768 : 200);
      run_case($sformatf("rnd%0d", t), it, pr, dl, sh, 1'($urandom), 1'($urandom),
               1'($urandom), sa, $urandom_range(1, 6));
    end

    reset_mid_run();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/xyolo_macc_v2.md
Name: xyolo_macc_v2

Overview:
- Next-generation Versat YOLO functional unit: a single-lane, 4-stage pipelined multiply-accumulate with a built-in iteration/period sequencer and a post-processing stage.
- Compared with the first-generation FU, it adds parametrised data and accumulator widths, round-half-up before the right shift, signed output saturation, a MAXPOOL mode, valid/stall handshaking, and busy/done status.
- Sits in the Versat datapath: operands come from flow-selected memories, `out_data` goes back to flow_out.

Parameters:
- DATA_W, 16: signed operand and output width.
- ACC_W, 40: signed accumulator width; must be >= 2*DATA_W+4.
- CNT_W, 10: width of the iterations, period and delay counters.
- SHIFT_W, 5: width of the shift amount.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start pulse; sampled in IDLE only.
- en  in  1  advance enable; 0 freezes the sequencer and the whole pipeline.
- iterations  in  CNT_W  number of outputs (windows) to produce.
- period  in  CNT_W  samples per window.
- delay  in  CNT_W  idle cycles between run and the first sample.
- shift  in  SHIFT_W  output right-shift and bias left-shift amount.
- bias  in  1  1: initialise the accumulator with op_c<<<shift; 0: initialise with 0.
- leaky  in  1  enable leaky ReLU (negative values >>> 3).
- mode  in  1  0: MAC; 1: MAXPOOL.
- op_a, op_b, op_c  in  DATA_W each  signed operands.
- out_data  out  DATA_W  result.
- out_valid  out  1  result qualifier.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- **Reset:** rst_n low asynchronously clears the FSM to IDLE and clears all counters and pipeline registers. `out_data`=0, `out_valid`=0, `busy`=0, `done`=0. Reset mid-run aborts the run with no further outputs and no done pulse.
- **Config latch:** all config inputs are latched on run acceptance. Changes during a run have no effect.
- **FSM:**
  - IDLE: on run=1 go to DELAY, `busy`=1. run while busy is ignored.
  - DELAY: count `delay` enabled cycles, then go to RUN. delay=0 goes to RUN on the next cycle.
  - RUN: sample counter k runs 0..period-1 and window counter i runs 0..iterations-1.
    - One sample is consumed per en=1 cycle.
    - After k=period-1 with i=iterations-1, go to DRAIN.
  - DRAIN: wait until the last `out_valid` has been issued. Pulse `done` on the following cycle, then go to IDLE with `busy`=0.
  - iterations=0 or period=0: DELAY/RUN are skipped and `done` pulses 2 cycles after run, with no `out_valid`.
- **Pipeline (each stage advances only when en=1):**
  - S1 registers op_a, op_b, op_c and the first(k==0) and last(k==period-1) flags.
  - S2 registers the full-width signed product a*b, sign-extended to ACC_W, and the init value.
  - S3 accumulates:
    - MAC: acc = (first ? init : acc) + prod.
    - MAXPOOL: acc = first ? a : max(acc, a).
    - The init value is sign-extended op_c <<< shift when bias=1, otherwise 0.
  - S4 post-processes and registers `out_data`; `out_valid` = the last flag from S3.
  - Latency: the sample with last=1 presented on cycle t yields `out_valid` on cycle t+4, given en=1 throughout.
  - en=0 holds `out_valid` and `out_data` unchanged.
- **Post-processing, MAC mode:**
  - r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If leaky and the saturated value is negative: out = sat >>> 3 (floor); otherwise out = sat.
- **Post-processing, MAXPOOL mode:** out = acc[DATA_W-1:0]. shift, bias and leaky are ignored.
- **Accumulator width:** must not overflow within the legal ACC_W constraint.
- **Back-to-back windows:** no bubble between windows. The first flag overrides accumulation in the same cycle the previous last sample completes.

Test Plan:
- DATA_W=16, MAC, period=3, iterations=1, bias=0, shift=0, a={2,3,4}, b={5,6,7} -> one `out_valid`, `out_data`=56, 4 cycles after the last sample; `done` pulses the cycle after that.
- MAC, period=1, a=b=32767, shift=0 -> `out_data`=32767 (saturated); a=-32768, b=32767 -> `out_data`=-32768.
- Rounding, period=1, bias=0, shift=2: a=6,b=1 -> 2; a=5,b=1 -> 1; a=-6,b=1 -> -1. Leaky=1, shift=0, a=-80,b=1 -> -10.
- Bias=1, shift=4, op_c=3, period=1, a=2, b=5 -> acc=58, out=(58+8)>>>4=4.
- MAXPOOL, period=3, iterations=2, a={-3,7,2, -9,-4,-5} -> outputs 7 then -4 on consecutive windows, no bubble.
- Stall and reset:
  - en held 0 for 5 cycles mid-window -> results identical to the unstalled run, shifted by 5 cycles.
  - rst_n pulsed low mid-run -> `busy`/`out_valid`/`done` go 0 immediately and no output follows.
  - iterations=0 -> `done` 2 cycles after run, no `out_valid`.
